// File: rtl/day_of_year_pkg.sv
// Shared constants for the day-of-year display: segment codes, month boundaries, count range.
package day_of_year_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Last day-of-year of Jan, Feb and Mar.
  localparam logic [6:0] NL_END_JAN = 7'd31;
  localparam logic [6:0] NL_END_FEB = 7'd59;
  localparam logic [6:0] NL_END_MAR = 7'd90;
  localparam logic [6:0] L_END_JAN  = 7'd31;
  localparam logic [6:0] L_END_FEB  = 7'd60;
  localparam logic [6:0] L_END_MAR  = 7'd91;

  localparam logic [6:0] N_MIN = 7'd1;
  localparam logic [6:0] N_MAX = 7'd99;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Valid for 0..99 only.
  function automatic bcd2_t bin_to_bcd2(input logic [6:0] v);
    bcd2_t r;
    r.tens = 4'(v / 7'd10);
    r.ones = 4'(v % 7'd10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Active-low seven-segment decoder with DP off; non-BCD codes blank the digit.
module bcd_to_seg7
  import day_of_year_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/day_of_year_display.sv
// Day-of-year counter (01..99) with month/day decode onto six seven-segment digits.
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit on HEX5 and HEX1.
module day_of_year_display
  import day_of_year_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic       ADC_CLK_10,
  input  logic [1:0] KEY,
  input  logic [9:8] SW,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic [1:0] LEDR
);

  localparam int DIV_W = $clog2(TICK_DIV);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] ZERO_TENS = SEG_BLANK;
`else
  localparam logic [7:0] ZERO_TENS = SEG_0;
`endif

  logic             rst;
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic             leap, dir_down, paused;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  bcd2_t            n_q, n_d;
  logic [6:0]       n_bin;
  logic [6:0]       end_jan, end_feb, end_mar, day_bin;
  logic [3:0]       month;
  bcd2_t            day_bcd;
  logic [7:0]       seg_n_tens, seg_n_ones, seg_month, seg_day_tens, seg_day_ones;
  logic [7:0]       hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
  logic [7:0]       hex4_q, hex4_d, hex5_q, hex5_d;
  logic [1:0]       ledr_q, ledr_d;

  assign rst      = KEY[0];
  assign leap     = sync2_q[0];
  assign dir_down = sync2_q[1];
  assign paused   = sync2_q[2];

  always_comb begin
    sync1_d = {KEY[1], SW[8], SW[9]};
    sync2_d = sync1_q;
    tick    = (div_q == DIV_W'(TICK_DIV - 1));
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    n_bin   = 7'(n_q.tens) * 7'd10 + 7'(n_q.ones);
    n_d     = n_q;
    if (tick && !paused) begin
      if (!dir_down) begin
        if (n_bin == N_MAX) begin
          n_d = bin_to_bcd2(N_MIN);
        end else if (n_q.ones == 4'd9) begin
          n_d.tens = n_q.tens + 4'd1;
          n_d.ones = 4'd0;
        end else begin
          n_d.ones = n_q.ones + 4'd1;
        end
      end else begin
        if (n_bin == N_MIN) begin
          n_d = bin_to_bcd2(N_MAX);
        end else if (n_q.ones == 4'd0) begin
          n_d.tens = n_q.tens - 4'd1;
          n_d.ones = 4'd9;
        end else begin
          n_d.ones = n_q.ones - 4'd1;
        end
      end
    end
  end

  always_comb begin
    end_jan = leap ? L_END_JAN : NL_END_JAN;
    end_feb = leap ? L_END_FEB : NL_END_FEB;
    end_mar = leap ? L_END_MAR : NL_END_MAR;
    month   = 4'd4;
    day_bin = n_bin - end_mar;
    if (n_bin <= end_jan) begin
      month   = 4'd1;
      day_bin = n_bin;
    end else if (n_bin <= end_feb) begin
      month   = 4'd2;
      day_bin = n_bin - end_jan;
    end else if (n_bin <= end_mar) begin
      month   = 4'd3;
      day_bin = n_bin - end_feb;
    end
    day_bcd = bin_to_bcd2(day_bin);
  end

  bcd_to_seg7 u_seg_n_tens   (.bcd(n_q.tens),     .seg(seg_n_tens));
  bcd_to_seg7 u_seg_n_ones   (.bcd(n_q.ones),     .seg(seg_n_ones));
  bcd_to_seg7 u_seg_month    (.bcd(month),        .seg(seg_month));
  bcd_to_seg7 u_seg_day_tens (.bcd(day_bcd.tens), .seg(seg_day_tens));
  bcd_to_seg7 u_seg_day_ones (.bcd(day_bcd.ones), .seg(seg_day_ones));

  always_comb begin
    hex5_d = (n_q.tens == 4'd0) ? ZERO_TENS : seg_n_tens;
    hex4_d = seg_n_ones;
    hex2_d = seg_month;
    hex1_d = (day_bcd.tens == 4'd0) ? ZERO_TENS : seg_day_tens;
    hex0_d = seg_day_ones;
    ledr_d = {paused, leap};
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      n_q     <= bin_to_bcd2(N_MIN);
      hex5_q  <= ZERO_TENS;
      hex4_q  <= SEG_1;
      hex2_q  <= SEG_1;
      hex1_q  <= ZERO_TENS;
      hex0_q  <= SEG_1;
      ledr_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      div_q   <= div_d;
      n_q     <= n_d;
      hex5_q  <= hex5_d;
      hex4_q  <= hex4_d;
      hex2_q  <= hex2_d;
      hex1_q  <= hex1_d;
      hex0_q  <= hex0_d;
      ledr_q  <= ledr_d;
    end
  end

  assign HEX5 = hex5_q;
  assign HEX4 = hex4_q;
  assign HEX3 = SEG_BLANK;
  assign HEX2 = hex2_q;
  assign HEX1 = hex1_q;
  assign HEX0 = hex0_q;
  assign LEDR = ledr_q;

endmodule

// File: tb/tb_day_of_year_display.sv
// Directed bench for day_of_year_display with TICK_DIV=2 (one tick every two clocks).
module tb_day_of_year_display;

  logic       clk = 1'b0;
  logic [1:0] key = 2'b01;
  logic [9:8] sw  = 2'b00;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [1:0] ledr;
  logic [47:0] disp;
  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] Z = 8'hFF;
`else
  localparam logic [7:0] Z = 8'hC0;
`endif
  localparam logic [47:0] DISP_01 = {Z, 8'hF9, 8'hFF, 8'hF9, Z, 8'hF9};

  day_of_year_display #(.TICK_DIV(2)) dut (
    .ADC_CLK_10(clk), .KEY(key), .SW(sw),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3),
    .HEX4(hex4), .HEX5(hex5), .LEDR(ledr)
  );

  always #50 clk = ~clk;
  assign disp = {hex5, hex4, hex3, hex2, hex1, hex0};

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sample points sit one edge after each tick, so the display equals the current N.
  task automatic ticks(input int k);
    edges(2 * k);
  endtask

  task automatic test_reset();
    key = 2'b01; sw = 2'b00;
    edges(2);
    total_cnt++;
    if (disp !== DISP_01) $display("FAIL reset_disp got %h exp %h", disp, DISP_01);
    else pass_cnt++;
    total_cnt++;
    if (ledr !== 2'b00) $display("FAIL reset_ledr got %b exp %b", ledr, 2'b00);
    else pass_cnt++;
    key = 2'b00;
    edges(1);
    total_cnt++;
    if (disp !== DISP_01) $display("FAIL release_disp got %h exp %h", disp, DISP_01);
    else pass_cnt++;
  endtask

  task automatic test_count_up();
    logic [47:0] exp;
    ticks(31);
    exp = {8'hB0, 8'hA4, 8'hFF, 8'hA4, Z, 8'hF9};
    total_cnt++;
    if (disp !== exp) $display("FAIL n32_disp got %h exp %h", disp, exp);
    else pass_cnt++;
    ticks(27);
    exp = {8'h92, 8'h90, 8'hFF, 8'hA4, 8'hA4, 8'h80};
    total_cnt++;
    if (disp !== exp) $display("FAIL n59_disp got %h exp %h", disp, exp);
    else pass_cnt++;
    key = 2'b10;  // pause: still synchronizing during the next tick
    ticks(1);
    exp = {8'h82, 8'hC0, 8'hFF, 8'hB0, Z, 8'hF9};
    total_cnt++;
    if (disp !== exp) $display("FAIL n60_disp got %h exp %h", disp, exp);
    else pass_cnt++;
  endtask

  task automatic test_leap();
    logic [47:0] exp;
    sw = 2'b10;
    ticks(2);
    exp = {8'h82, 8'hC0, 8'hFF, 8'hA4, 8'hA4, 8'h90};
    total_cnt++;
    if (disp !== exp) $display("FAIL leap60_disp got %h exp %h", disp, exp);
    else pass_cnt++;
    total_cnt++;
    if (ledr !== 2'b11) $display("FAIL leap60_ledr got %b exp %b", ledr, 2'b11);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    logic [47:0] exp;
    exp = {8'h82, 8'hC0, 8'hFF, 8'hA4, 8'hA4, 8'h90};
    ticks(5);
    total_cnt++;
    if (disp !== exp) $display("FAIL paused_disp got %h exp %h", disp, exp);
    else pass_cnt++;
    total_cnt++;
    if (ledr !== 2'b11) $display("FAIL paused_ledr got %b exp %b", ledr, 2'b11);
    else pass_cnt++;
    key = 2'b00;
    ticks(1);
    total_cnt++;
    if (disp !== exp) $display("FAIL unpause_sync_disp got %h exp %h", disp, exp);
    else pass_cnt++;
    ticks(1);
    exp = {8'h82, 8'hF9, 8'hFF, 8'hB0, Z, 8'hF9};
    total_cnt++;
    if (disp !== exp) $display("FAIL leap61_disp got %h exp %h", disp, exp);
    else pass_cnt++;
    total_cnt++;
    if (ledr !== 2'b01) $display("FAIL resumed_ledr got %b exp %b", ledr, 2'b01);
    else pass_cnt++;
  endtask

  task automatic test_wrap_up();
    logic [47:0] exp;
    ticks(38);
    exp = {8'h90, 8'h90, 8'hFF, 8'h99, Z, 8'h80};
    total_cnt++;
    if (disp !== exp) $display("FAIL leap99_disp got %h exp %h", disp, exp);
    else pass_cnt++;
    ticks(1);
    total_cnt++;
    if (disp !== DISP_01) $display("FAIL wrap_up_disp got %h exp %h", disp, DISP_01);
    else pass_cnt++;
  endtask

  task automatic test_down();
    logic [47:0] exp;
    sw = 2'b01;  // down, non-leap; one more up tick happens during sync
    ticks(1);
    exp = {Z, 8'hA4, 8'hFF, 8'hF9, Z, 8'hA4};
    total_cnt++;
    if (disp !== exp) $display("FAIL dir_sync_disp got %h exp %h", disp, exp);
    else pass_cnt++;
    ticks(1);
    total_cnt++;
    if (disp !== DISP_01) $display("FAIL down01_disp got %h exp %h", disp, DISP_01);
    else pass_cnt++;
    total_cnt++;
    if (ledr !== 2'b00) $display("FAIL down_ledr got %b exp %b", ledr, 2'b00);
    else pass_cnt++;
    ticks(1);
    exp = {8'h90, 8'h90, 8'hFF, 8'h99, Z, 8'h90};
    total_cnt++;
    if (disp !== exp) $display("FAIL wrap_down_disp got %h exp %h", disp, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [47:0] exp;
    ticks(54);
    exp = {8'h99, 8'h92, 8'hFF, 8'hA4, 8'hF9, 8'h99};
    total_cnt++;
    if (disp !== exp) $display("FAIL n45_disp got %h exp %h", disp, exp);
    else pass_cnt++;
    key = 2'b11;
    edges(1);
    total_cnt++;
    if (disp !== DISP_01) $display("FAIL mid_reset_disp got %h exp %h", disp, DISP_01);
    else pass_cnt++;
    total_cnt++;
    if (ledr !== 2'b00) $display("FAIL mid_reset_ledr got %b exp %b", ledr, 2'b00);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_leap();
    test_pause();
    test_wrap_up();
    test_down();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
